sel_dec: RTL and testbench

- Select-and-decode unit for the 32-bit datapath: the destination-side counterpart of the bus source encoder.
- Latches the instruction word from the bus into an internal IR and extracts the Ra/Rb/Rc fields selected by Gra/Grb/Grc.
- Produces registered one-hot R0..R15 load enables (Rin_en) and drive enables (Rout_en), the opcode, and the sign-extended constant C.
- Sits between the control unit and the register file. Its Rout_en bits feed the bus encoder's register out-enable inputs.

---
 rtl/sel_dec.sv | 97 +++++++++
 tb/tb_sel_dec.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_dec.sv
`default_nettype none
// ============================================================================
// Module   : sel_dec
// Purpose  : Instruction register plus Ra/Rb/Rc select-and-decode producing
//            registered one-hot register load/drive enables, opcode and C.
//            Optional SEL_DEC_IR_FWD_EN decodes bus_in while IRin is high.
// Revision : 1.0 - initial release
// ============================================================================
module sel_dec #(
    parameter int DATA_W = 32,
    parameter int C_W    = 19
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              IRin,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              Rin,
    input  logic              Rout,
    input  logic              BAout,
    output logic [15:0]       Rin_en,
    output logic [15:0]       Rout_en,
    output logic              r0_zero,
    output logic [4:0]        opcode,
    output logic [DATA_W-1:0] C_sext,
    output logic              sel_err
);

    logic [DATA_W-1:0] r_ir;
    logic [15:0]       r_rin_en;
    logic [15:0]       r_rout_en;
    logic              r_r0_zero;
    logic              r_sel_err;

    logic [DATA_W-1:0] w_dec_word;
    logic              w_sel_valid;
    logic              w_conflict;
    logic              w_ba_r0;
    logic [3:0]        w_idx;
    logic [15:0]       w_onehot;
    logic [15:0]       w_rin_nxt;
    logic [15:0]       w_rout_nxt;

`ifdef SEL_DEC_IR_FWD_EN
    // Forward the incoming instruction so decode need not wait for IR.
    assign w_dec_word = IRin ? bus_in : r_ir;
`else
    assign w_dec_word = r_ir;
`endif

    assign opcode = w_dec_word[DATA_W-1 -: 5];
    assign C_sext = {{(DATA_W-C_W){w_dec_word[C_W-1]}}, w_dec_word[C_W-1:0]};

    always_comb begin
        w_sel_valid = (Gra & ~Grb & ~Grc) | (~Gra & Grb & ~Grc) | (~Gra & ~Grb & Grc);
        w_conflict  = ((Gra & Grb) | (Gra & Grc) | (Grb & Grc)) & (Rin | Rout | BAout);
        w_idx       = 4'd0;
        if (Gra)
            w_idx = w_dec_word[26:23];
        else if (Grb)
            w_idx = w_dec_word[22:19];
        else if (Grc)
            w_idx = w_dec_word[18:15];
        w_onehot   = 16'h0001 << w_idx;
        // BAout on R0 means "drive zero", so no register drives the bus.
        w_ba_r0    = BAout & w_sel_valid & (w_idx == 4'd0);
        w_rin_nxt  = (Rin & w_sel_valid) ? w_onehot : 16'h0000;
        w_rout_nxt = ((Rout | BAout) & w_sel_valid & ~w_ba_r0) ? w_onehot : 16'h0000;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ir      <= '0;
            r_rin_en  <= '0;
            r_rout_en <= '0;
            r_r0_zero <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            if (IRin)
                r_ir <= bus_in;
            r_rin_en  <= w_rin_nxt;
            r_rout_en <= w_rout_nxt;
            r_r0_zero <= w_ba_r0;
            if (w_conflict)
                r_sel_err <= 1'b1;
        end
    end

    assign Rin_en  = r_rin_en;
    assign Rout_en = r_rout_en;
    assign r0_zero = r_r0_zero;
    assign sel_err = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_sel_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_sel_dec
// Purpose  : Directed self-checking bench for sel_dec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sel_dec;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] bus_in;
    logic        IRin, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [15:0] Rin_en, Rout_en;
    logic        r0_zero, sel_err;
    logic [4:0]  opcode;
    logic [31:0] C_sext;

    int n_checks = 0;
    int n_fail   = 0;

    sel_dec #(.DATA_W(32), .C_W(19)) dut (
        .clk     (clk),
        .clr     (clr),
        .bus_in  (bus_in),
        .IRin    (IRin),
        .Gra     (Gra),
        .Grb     (Grb),
        .Grc     (Grc),
        .Rin     (Rin),
        .Rout    (Rout),
        .BAout   (BAout),
        .Rin_en  (Rin_en),
        .Rout_en (Rout_en),
        .r0_zero (r0_zero),
        .opcode  (opcode),
        .C_sext  (C_sext),
        .sel_err (sel_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic ga, gb, gc, ri, ro, ba);
        Gra = ga; Grb = gb; Grc = gc; Rin = ri; Rout = ro; BAout = ba;
    endtask

    task automatic load_ir(input logic [31:0] w);
        bus_in = w;
        IRin   = 1'b1;
        tick();
        IRin   = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; bus_in = '0; IRin = 1'b0;
        ctrl(0, 0, 0, 0, 0, 0);
        tick(); tick();
        clr = 1'b0;
        n_checks++;
        if ({Rin_en, Rout_en, r0_zero, sel_err} !== 34'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {Rin_en, Rout_en, r0_zero, sel_err});
        end
        n_checks++;
        if ({opcode, C_sext} !== 37'd0) begin
            n_fail++; $display("FAIL reset_ir: got %h expected 0", {opcode, C_sext});
        end
        // Mid-cycle clear with an active load enable
        load_ir(32'hF900_0000);
        ctrl(1, 0, 0, 1, 0, 0);
        tick();
        n_checks++;
        if (Rin_en !== 16'h0004) begin
            n_fail++; $display("FAIL pre_clr_rin: got %h expected %h", Rin_en, 16'h0004);
        end
        #1 clr = 1'b1;
        #1;
        n_checks++;
        if ({Rin_en, Rout_en, r0_zero, sel_err, opcode, C_sext} !== 71'd0) begin
            n_fail++; $display("FAIL async_clr: got %h expected 0", {Rin_en, Rout_en, r0_zero, sel_err, opcode, C_sext});
        end
        #1 clr = 1'b0;
        tick();
        n_checks++;
        if (Rin_en !== 16'h0001) begin
            n_fail++; $display("FAIL post_clr_idx0: got %h expected %h", Rin_en, 16'h0001);
        end
        ctrl(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_decode();
        load_ir(32'h1A9B_0000);
        n_checks++;
        if (opcode !== 5'h03 || C_sext !== 32'h0003_0000) begin
            n_fail++; $display("FAIL opcode_c: got %h/%h expected 03/00030000", opcode, C_sext);
        end
        ctrl(1, 0, 0, 1, 0, 0);
        #3;
        n_checks++;
        if (Rin_en !== 16'h0000) begin
            n_fail++; $display("FAIL rin_latency: got %h expected 0", Rin_en);
        end
        tick();
        n_checks++;
        if (Rin_en !== 16'h0020 || Rout_en !== 16'h0000) begin
            n_fail++; $display("FAIL ra_rin: got %h/%h expected 0020/0000", Rin_en, Rout_en);
        end
        ctrl(0, 1, 0, 0, 1, 0);
        tick();
        n_checks++;
        if (Rout_en !== 16'h0008 || Rin_en !== 16'h0000) begin
            n_fail++; $display("FAIL rb_rout: got %h/%h expected 0008/0000", Rout_en, Rin_en);
        end
        ctrl(0, 0, 1, 0, 1, 0);
        tick();
        n_checks++;
        if (Rout_en !== 16'h0040) begin
            n_fail++; $display("FAIL rc_rout: got %h expected %h", Rout_en, 16'h0040);
        end
        ctrl(1, 0, 0, 1, 1, 0);
        tick();
        n_checks++;
        if (Rin_en !== 16'h0020 || Rout_en !== 16'h0020) begin
            n_fail++; $display("FAIL self_move: got %h/%h expected 0020/0020", Rin_en, Rout_en);
        end
        ctrl(0, 0, 0, 1, 1, 0);
        tick();
        n_checks++;
        if (Rin_en !== 16'h0000 || Rout_en !== 16'h0000) begin
            n_fail++; $display("FAIL no_select: got %h/%h expected 0000/0000", Rin_en, Rout_en);
        end
        ctrl(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_sext();
        load_ir(32'h0007_FFFF);
        n_checks++;
        if (C_sext !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sext_neg: got %h expected FFFFFFFF", C_sext);
        end
        load_ir(32'h0003_FFFF);
        n_checks++;
        if (C_sext !== 32'h0003_FFFF) begin
            n_fail++; $display("FAIL sext_pos: got %h expected 0003FFFF", C_sext);
        end
    endtask

    task automatic test_baout();
        load_ir(32'h0000_0000);
        ctrl(1, 0, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (Rout_en !== 16'h0000 || r0_zero !== 1'b1) begin
            n_fail++; $display("FAIL ba_r0: got %h/%b expected 0000/1", Rout_en, r0_zero);
        end
        ctrl(1, 0, 0, 0, 1, 1);
        tick();
        n_checks++;
        if (Rout_en !== 16'h0000 || r0_zero !== 1'b1) begin
            n_fail++; $display("FAIL ba_rout_r0: got %h/%b expected 0000/1", Rout_en, r0_zero);
        end
        ctrl(1, 0, 0, 0, 1, 0);
        tick();
        n_checks++;
        if (Rout_en !== 16'h0001 || r0_zero !== 1'b0) begin
            n_fail++; $display("FAIL rout_r0: got %h/%b expected 0001/0", Rout_en, r0_zero);
        end
        ctrl(0, 0, 0, 0, 0, 0);
        load_ir(32'h0200_0000);
        ctrl(1, 0, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (Rout_en !== 16'h0010 || r0_zero !== 1'b0) begin
            n_fail++; $display("FAIL ba_r4: got %h/%b expected 0010/0", Rout_en, r0_zero);
        end
        ctrl(0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (Rout_en !== 16'h0000 || r0_zero !== 1'b0) begin
            n_fail++; $display("FAIL ba_idle: got %h/%b expected 0000/0", Rout_en, r0_zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_ra;
        // IR holds Ra=4; bus carries Ra=5 while IRin and Gra are both high
        bus_in = 32'h1A9B_0000;
        IRin   = 1'b1;
        ctrl(1, 0, 0, 1, 0, 0);
`ifdef SEL_DEC_IR_FWD_EN
        exp_ra = 16'h0020;
`else
        exp_ra = 16'h0010;
`endif
        tick();
        IRin = 1'b0;
        n_checks++;
        if (Rin_en !== exp_ra) begin
            n_fail++; $display("FAIL irin_same_cycle: got %h expected %h", Rin_en, exp_ra);
        end
        tick();
        n_checks++;
        if (Rin_en !== 16'h0020) begin
            n_fail++; $display("FAIL ir_loaded: got %h expected 0020", Rin_en);
        end
        ctrl(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_conflict();
        ctrl(1, 1, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (sel_err !== 1'b0 || Rin_en !== 16'h0000) begin
            n_fail++; $display("FAIL g_only_no_err: got %b/%h expected 0/0000", sel_err, Rin_en);
        end
        ctrl(1, 1, 0, 1, 0, 0);
        tick();
        n_checks++;
        if (sel_err !== 1'b1 || Rin_en !== 16'h0000) begin
            n_fail++; $display("FAIL conflict_rin: got %b/%h expected 1/0000", sel_err, Rin_en);
        end
        ctrl(0, 1, 1, 0, 1, 0);
        tick();
        n_checks++;
        if (Rout_en !== 16'h0000) begin
            n_fail++; $display("FAIL conflict_rout: got %h expected 0000", Rout_en);
        end
        ctrl(0, 0, 0, 0, 0, 0);
        tick(); tick();
        n_checks++;
        if (sel_err !== 1'b1) begin
            n_fail++; $display("FAIL sel_err_sticky: got %b expected 1", sel_err);
        end
        clr = 1'b1;
        #2;
        clr = 1'b0;
        n_checks++;
        if (sel_err !== 1'b0) begin
            n_fail++; $display("FAIL sel_err_clr: got %b expected 0", sel_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_sext();
        test_baout();
        test_back_to_back();
        test_conflict();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
